// File: rtl/voice_sched_pkg.sv
// Shared constants, state encodings and the note-to-increment generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package voice_sched_pkg;

    localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
    localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;

    localparam int DEF_NUM_VOICES = 8;
    localparam int DEF_PHASE_W    = 32;
    localparam int DEF_ROM_ADDR_W = 10;
    localparam int DEF_SAMPLE_W   = 24;
    localparam int DEF_TICK_DIV   = 100;
    localparam int DEF_CLK_HZ     = 50_000_000;

    localparam int NOTE_W = 7;
    localparam int VEL_W  = 7;
    localparam int MIX_W  = 8;
    localparam int ACC_W  = 18;

    // 2^(1/12): one equal-tempered semitone
    localparam real SEMITONE = 1.0594630943592953;

    typedef enum logic [1:0] {P_IDLE, P_NOTE, P_VEL} parse_state_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} seq_state_e;

    // inc = round(2^phase_w * f_note / f_s), f_note = 440*2^((n-69)/12), f_s = clk_hz/tick_div.
    // Evaluated at elaboration only; the integer split keeps results above 2^31 exact.
    function automatic logic [63:0] calc_note_inc(input int note, input int phase_w,
                                                  input int tick_div, input int clk_hz);
        real f;
        real inc;
        int  hi;
        int  lo;
        f = 440.0;
        for (int i = 69; i < note; i++) f = f * SEMITONE;
        for (int i = note; i < 69; i++) f = f / SEMITONE;
        inc = f * $itor(tick_div) / $itor(clk_hz);
        for (int i = 0; i < phase_w; i++) inc = inc * 2.0;
        inc = inc + 0.5;
        hi  = $rtoi(inc / 65536.0);
        lo  = $rtoi(inc - $itor(hi) * 65536.0);
        return (64'(hi) << 16) + 64'(lo);
    endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// MIDI input, shared ROM port and mixer output bundle of the voice scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a strobe or a level.
interface voice_scheduler_if import voice_sched_pkg::*; #(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int ROM_ADDR_W = DEF_ROM_ADDR_W,
    parameter int SAMPLE_W   = DEF_SAMPLE_W
);
    logic                  midi_valid;
    logic [7:0]            midi_byte;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [SAMPLE_W-1:0]   rom_q;
    logic [MIX_W-1:0]      mix_out;
    logic                  mix_valid;
    logic [NUM_VOICES-1:0] voice_active;
    logic                  note_drop;

    modport slave (
        input  midi_valid, midi_byte, rom_q,
        output rom_addr, mix_out, mix_valid, voice_active, note_drop
    );

    modport master (
        output midi_valid, midi_byte, rom_q,
        input  rom_addr, mix_out, mix_valid, voice_active, note_drop
    );
endinterface

// File: rtl/voice_scheduler_note_inc_lut.sv
// Combinational MIDI note -> phase increment lookup (128 entries).
// Latency: 0 cycles.
// Backpressure: none.
module note_inc_lut import voice_sched_pkg::*; #(
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int CLK_HZ   = DEF_CLK_HZ
) (
    input  logic [NOTE_W-1:0]  note_i,
    output logic [PHASE_W-1:0] inc_o
);
    logic [PHASE_W-1:0] inc_table [128];

    for (genvar g = 0; g < 128; g++) begin : g_tab
        localparam logic [63:0] INC = calc_note_inc(g, PHASE_W, TICK_DIV, CLK_HZ);
        assign inc_table[g] = INC[PHASE_W-1:0];
    end

    assign inc_o = inc_table[note_i];
endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic MIDI voice allocator + per-tick time-multiplexed wavetable scan and mixer.
// Latency: commit visible 1 cycle after the velocity byte; mix_valid N+2 cycles after a tick.
// Backpressure: none; MIDI bytes are accepted every cycle, full voice table pulses note_drop.
module voice_scheduler import voice_sched_pkg::*; #(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int ROM_ADDR_W = DEF_ROM_ADDR_W,
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int CLK_HZ     = DEF_CLK_HZ
) (
    input logic              clk,
    input logic              reset,
    voice_scheduler_if.slave bus
);
    localparam int VIDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W  = $clog2(TICK_DIV);

    // ---------------- MIDI parser ----------------
    parse_state_e       p_state_q, p_state_d;
    logic               cmd_on_q, cmd_on_d;
    logic [NOTE_W-1:0]  p_note_q, p_note_d;
    logic               commit;
    logic [VEL_W-1:0]   commit_vel;
    logic               note_on_cmt;
    logic               note_off_cmt;

    // Parser next state: status bytes always restart, data bytes advance NOTE -> VEL -> commit
    always_comb begin
        p_state_d = p_state_q;
        cmd_on_d  = cmd_on_q;
        p_note_d  = p_note_q;
        commit    = 1'b0;
        if (bus.midi_valid) begin
            if (bus.midi_byte[7]) begin
                p_state_d = P_IDLE;
                if (bus.midi_byte == MIDI_NOTE_ON) begin
                    cmd_on_d  = 1'b1;
                    p_state_d = P_NOTE;
                end else if (bus.midi_byte == MIDI_NOTE_OFF) begin
                    cmd_on_d  = 1'b0;
                    p_state_d = P_NOTE;
                end
            end else begin
                case (p_state_q)
                    P_NOTE: begin
                        p_note_d  = bus.midi_byte[NOTE_W-1:0];
                        p_state_d = P_VEL;
                    end
                    P_VEL: begin
                        commit    = 1'b1;
                        p_state_d = P_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Parser state register
    always_ff @(posedge clk) begin
        if (reset) begin
            p_state_q <= P_IDLE;
            cmd_on_q  <= 1'b0;
            p_note_q  <= '0;
        end else begin
            p_state_q <= p_state_d;
            cmd_on_q  <= cmd_on_d;
            p_note_q  <= p_note_d;
        end
    end

    assign commit_vel   = bus.midi_byte[VEL_W-1:0];
    assign note_on_cmt  = commit && cmd_on_q && (commit_vel != '0);
    assign note_off_cmt = commit && !note_on_cmt;

    // ---------------- voice table ----------------
    logic [NUM_VOICES-1:0] active_q;
    logic [NOTE_W-1:0]     v_note_q  [NUM_VOICES];
    logic [VEL_W-1:0]      v_vel_q   [NUM_VOICES];
    logic [PHASE_W-1:0]    v_inc_q   [NUM_VOICES];
    logic [PHASE_W-1:0]    phase_q   [NUM_VOICES];
    logic                  note_drop_q;
    logic                  hit_any, free_any;
    logic [VIDX_W-1:0]     hit_idx, free_idx;
    logic [PHASE_W-1:0]    new_inc;

    note_inc_lut #(
        .PHASE_W  (PHASE_W),
        .TICK_DIV (TICK_DIV),
        .CLK_HZ   (CLK_HZ)
    ) u_note_inc_lut (
        .note_i (p_note_q),
        .inc_o  (new_inc)
    );

    // Lowest-index active voice holding the parsed note, and lowest-index free voice
    always_comb begin
        hit_any  = 1'b0;
        free_any = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (active_q[i] && (v_note_q[i] == p_note_q)) begin
                hit_any = 1'b1;
                hit_idx = VIDX_W'(i);
            end
            if (!active_q[i]) begin
                free_any = 1'b1;
                free_idx = VIDX_W'(i);
            end
        end
    end

    // ---------------- tick counter and scan sequencer ----------------
    seq_state_e         s_state_q, s_state_d;
    logic [CNT_W-1:0]   tick_cnt_q;
    logic               tick;
    logic [VIDX_W-1:0]  slot_q, slot_d;
    logic               issue;

    assign tick = (tick_cnt_q == CNT_W'(TICK_DIV - 1));

    // Tick counter: free-running 0..TICK_DIV-1
    always_ff @(posedge clk) begin
        if (reset)     tick_cnt_q <= '0;
        else if (tick) tick_cnt_q <= '0;
        else           tick_cnt_q <= tick_cnt_q + CNT_W'(1);
    end

    // Sequencer next state: one issue slot per voice, then drain the ROM pipe and publish
    always_comb begin
        s_state_d = s_state_q;
        slot_d    = slot_q;
        issue     = 1'b0;
        case (s_state_q)
            S_IDLE: begin
                if (tick) begin
                    s_state_d = S_ISSUE;
                    slot_d    = '0;
                end
            end
            S_ISSUE: begin
                issue  = 1'b1;
                slot_d = slot_q + VIDX_W'(1);
                if (slot_q == VIDX_W'(NUM_VOICES - 1)) s_state_d = S_DRAIN;
            end
            S_DRAIN: s_state_d = S_OUT;
            S_OUT:   s_state_d = S_IDLE;
            default: s_state_d = S_IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            s_state_q <= S_IDLE;
            slot_q    <= '0;
        end else begin
            s_state_q <= s_state_d;
            slot_q    <= slot_d;
        end
    end

    // Voice table update; a commit to the slot being issued overrides its phase advance
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q    <= '0;
            note_drop_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                v_note_q[i] <= '0;
                v_vel_q[i]  <= '0;
                v_inc_q[i]  <= '0;
                phase_q[i]  <= '0;
            end
        end else begin
            note_drop_q <= note_on_cmt && !hit_any && !free_any;
            if (issue && active_q[slot_q]) phase_q[slot_q] <= phase_q[slot_q] + v_inc_q[slot_q];
            if (note_on_cmt) begin
                if (hit_any) begin
                    v_vel_q[hit_idx] <= commit_vel;
                    phase_q[hit_idx] <= '0;
                end else if (free_any) begin
                    active_q[free_idx] <= 1'b1;
                    v_note_q[free_idx] <= p_note_q;
                    v_vel_q[free_idx]  <= commit_vel;
                    v_inc_q[free_idx]  <= new_inc;
                    phase_q[free_idx]  <= '0;
                end
            end else if (note_off_cmt && hit_any) begin
                active_q[hit_idx] <= 1'b0;
                phase_q[hit_idx]  <= '0;
            end
        end
    end

    // ---------------- ROM address, pipeline and mixer ----------------
    logic [ROM_ADDR_W-1:0] cur_addr;
    logic [ROM_ADDR_W-1:0] addr_hold_q;
    logic                  pipe_vld_q, pipe_act_q;
    logic [VEL_W-1:0]      pipe_vel_q;
    logic [7:0]            rom_top;
    logic [14:0]           prod;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [MIX_W-1:0]      mix_out_q;
    logic                  mix_valid_q;
    logic                  unused_rom_lsbs;

    assign cur_addr        = phase_q[slot_q][PHASE_W-1 -: ROM_ADDR_W];
    assign rom_top         = bus.rom_q[SAMPLE_W-1 -: 8];
    assign unused_rom_lsbs = ^bus.rom_q[SAMPLE_W-9:0];
    assign prod            = {7'd0, rom_top} * {8'd0, pipe_vel_q};

    // Accumulator next value: add the returning slot, clear once the mix is published
    always_comb begin
        acc_d = acc_q;
        if (pipe_vld_q && pipe_act_q) acc_d = acc_q + ACC_W'(prod);
        if (s_state_q == S_OUT)       acc_d = '0;
    end

    // Slot pipeline aligned to rom_q, address hold, accumulator and published mix
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_hold_q <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_act_q  <= 1'b0;
            pipe_vel_q  <= '0;
            acc_q       <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
        end else begin
            if (issue) addr_hold_q <= cur_addr;
            pipe_vld_q  <= issue;
            pipe_act_q  <= active_q[slot_q];
            pipe_vel_q  <= v_vel_q[slot_q];
            acc_q       <= acc_d;
            mix_valid_q <= (s_state_q == S_DRAIN);
            if (s_state_q == S_DRAIN) mix_out_q <= acc_d[ACC_W-1 -: MIX_W];
        end
    end

    assign bus.rom_addr     = issue ? cur_addr : addr_hold_q;
    assign bus.mix_out      = mix_out_q;
    assign bus.mix_valid    = mix_valid_q;
    assign bus.voice_active = active_q;
    assign bus.note_drop    = note_drop_q;
endmodule
